mem_arbiter: RTL and testbench

//  Arbitrates the datapath's instruction-fetch and data-access requests onto one

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_starve_ctr.sv | 39 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM word, RAM handshake state and
// arbiter FSM state, plus default tuning constants.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Handshake state reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM: IDLE always separates two grants.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int RETRY_MAX_DEF    = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters (fetch / data), the arbiter and the RAM.
// The arbiter uses the slave view; the environment driving requests and
// modelling the RAM uses the master view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // instruction side
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    // data side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating counter of data completions that happened while fetch waited.
// limit_hit_o tells the arbiter to give fetch the next grant.
module mem_arbiter_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_hit_o
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-ported RAM. Data wins by default;
// after STARVE_LIMIT data completions with fetch pending, fetch wins once.
// RAM ERROR responses are retried until RETRY_MAX, then err_o latches.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int RETRY_MAX    = RETRY_MAX_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic          err_o
);
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);

    arb_state_t    state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q;

    logic data_req;
    logic granted_req;
    logic in_grant;
    logic last_error;
    logic done;
    logic starve_hit;
    logic starve_inc;
    logic starve_clr;

    assign data_req = bus.dREN | bus.dWEN;
    assign in_grant = (state_q != IDLE);

    // Live request of whoever currently owns the RAM; low means abort.
    always_comb begin
        granted_req = 1'b0;
        unique case (state_q)
            IGRANT:  granted_req = bus.iREN;
            DGRANT:  granted_req = data_req;
            default: granted_req = 1'b0;
        endcase
    end

    // An ERROR that would exhaust the retry budget terminates the transaction.
    assign last_error = in_grant && granted_req && (bus.ramstate == ERROR)
                        && (retry_q == RETRY_LAST);
    assign done       = in_grant && granted_req
                        && ((bus.ramstate == ACCESS) || last_error);

    // Starvation bookkeeping: data completions while fetch waits, reset by a
    // fetch completion or by fetch not asking while idle.
    assign starve_inc = done && (state_q == DGRANT) && bus.iREN;
    assign starve_clr = (done && (state_q == IGRANT))
                        || ((state_q == IDLE) && !bus.iREN);

    mem_arbiter_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK         (CLK),
        .RST         (RST),
        .inc_i       (starve_inc),
        .clr_i       (starve_clr),
        .limit_hit_o (starve_hit)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: pick a requester in IDLE, leave a grant on finish/abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_req && !(bus.iREN && starve_hit)) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                if (!granted_req || done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: RAM strobes follow the granted requester's live signals.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !done;
            end
            DGRANT: begin
                // A simultaneous read and write is treated as a write.
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = !done;
            end
            default: ;
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // Retry count, restarted each time the arbiter returns to IDLE.
    always_comb begin
        retry_d = retry_q;
        if (state_d == IDLE) begin
            retry_d = '0;
        end else if (in_grant && granted_req && (bus.ramstate == ERROR)) begin
            retry_d = retry_q + 1'b1;
        end
    end

    // Retry and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            if (last_error) begin
                err_q <= 1'b1;
            end
        end
    end

    // Error is visible in the same cycle the final ERROR response arrives.
    assign err_o = err_q | last_error;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table covering reset,
// priority, BUSY wait, ERROR retry, abort and reset-in-flight, followed by a
// hand-written starvation sequence.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst;
    logic err;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .RETRY_MAX    (3)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .bus   (bus),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string     name;
        logic      rst;
        logic      iren;
        word_t     iaddr;
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        ramstate_t rs;
        word_t     rload;
        logic      e_iwait;
        logic      e_dwait;
        logic      e_rren;
        logic      e_rwen;
        word_t     e_raddr;
        word_t     e_rstore;
        logic      e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string n, input logic r, input logic ir, input word_t ia,
        input logic dr, input logic dw, input word_t da, input word_t ds,
        input ramstate_t s, input word_t rl,
        input logic iw, input logic dwt, input logic rr, input logic rwn,
        input word_t ra, input word_t rsto, input logic e);
        vec_t v;
        v.name = n;   v.rst = r;     v.iren = ir;   v.iaddr = ia;
        v.dren = dr;  v.dwen = dw;   v.daddr = da;  v.dstore = ds;
        v.rs = s;     v.rload = rl;
        v.e_iwait = iw;  v.e_dwait = dwt; v.e_rren = rr; v.e_rwen = rwn;
        v.e_raddr = ra;  v.e_rstore = rsto; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        bus.iREN     = v.iren;
        bus.iaddr    = v.iaddr;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.daddr    = v.daddr;
        bus.dstore   = v.dstore;
        bus.ramstate = v.rs;
        bus.ramload  = v.rload;
    endtask

    initial begin
        vec_t v;
        int   ncomp;
        logic exp_seq [7];

        // name               rst ir iaddr      dr dw daddr      dstore        rs      rload         iw dw rr rw raddr      rstore        err
        vecs.push_back(mk("rst_c0",          1, 1, 32'h40,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("rst_c1",          1, 1, 32'h40,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("post_rst_idle",   0, 1, 32'h40,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("ifetch_zero_wait",0, 1, 32'h40,  0, 0, 32'h0,   32'h0,        ACCESS, 32'hAAAA0001, 0, 1, 1, 0, 32'h40,  32'h0,        0));
        vecs.push_back(mk("both_req_idle",   0, 1, 32'h44,  1, 1, 32'h100, 32'hDEADBEEF, FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("data_write_first",0, 1, 32'h44,  1, 1, 32'h100, 32'hDEADBEEF, ACCESS, 32'h0,        1, 0, 0, 1, 32'h100, 32'hDEADBEEF, 0));
        vecs.push_back(mk("fetch_idle",      0, 1, 32'h44,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("fetch_follows",   0, 1, 32'h44,  0, 0, 32'h0,   32'h0,        ACCESS, 32'hCAFE0044, 0, 1, 1, 0, 32'h44,  32'h0,        0));
        vecs.push_back(mk("busy_idle",       0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("busy_1",          0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        BUSY,   32'h0,        1, 1, 1, 0, 32'h200, 32'h0,        0));
        vecs.push_back(mk("busy_2",          0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        BUSY,   32'h0,        1, 1, 1, 0, 32'h200, 32'h0,        0));
        vecs.push_back(mk("busy_3",          0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        BUSY,   32'h0,        1, 1, 1, 0, 32'h200, 32'h0,        0));
        vecs.push_back(mk("busy_access",     0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        ACCESS, 32'h12345678, 1, 0, 1, 0, 32'h200, 32'h0,        0));
        vecs.push_back(mk("err_idle",        0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk("err_retry1",      0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        ERROR,  32'h0,        1, 1, 1, 0, 32'h300, 32'h0,        0));
        vecs.push_back(mk("err_retry2",      0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        ERROR,  32'h0,        1, 1, 1, 0, 32'h300, 32'h0,        0));
        vecs.push_back(mk("err_final",       0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        ERROR,  32'h0,        1, 0, 1, 0, 32'h300, 32'h0,        1));
        vecs.push_back(mk("err_sticky",      0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk("abort_idle",      0, 1, 32'h80,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk("abort_busy",      0, 1, 32'h80,  0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        1, 1, 1, 0, 32'h80,  32'h0,        1));
        vecs.push_back(mk("abort_drop",      0, 0, 32'h80,  0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        1, 1, 0, 0, 32'h80,  32'h0,        1));
        vecs.push_back(mk("abort_after",     0, 0, 32'h80,  0, 0, 32'h0,   32'h0,        ACCESS, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk("rd2wr_idle",      0, 0, 32'h0,   1, 0, 32'h400, 32'h55,       FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk("rd2wr_switch",    0, 0, 32'h0,   0, 1, 32'h400, 32'h55,       BUSY,   32'h0,        1, 1, 0, 1, 32'h400, 32'h55,       1));
        vecs.push_back(mk("rd2wr_done",      0, 0, 32'h0,   0, 1, 32'h400, 32'h55,       ACCESS, 32'h0,        1, 0, 0, 1, 32'h400, 32'h55,       1));
        vecs.push_back(mk("rstmid_idle",     0, 0, 32'h0,   1, 0, 32'h500, 32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk("rstmid_grant",    1, 0, 32'h0,   1, 0, 32'h500, 32'h0,        ERROR,  32'h0,        1, 1, 1, 0, 32'h500, 32'h0,        1));
        vecs.push_back(mk("rstmid_after",    0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        0));

        // Bring the FSM out of X before the table starts.
        drive(vecs[0]);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            chk({v.name, ".iwait"},    32'(bus.iwait),  32'(v.e_iwait));
            chk({v.name, ".dwait"},    32'(bus.dwait),  32'(v.e_dwait));
            chk({v.name, ".ramREN"},   32'(bus.ramREN), 32'(v.e_rren));
            chk({v.name, ".ramWEN"},   32'(bus.ramWEN), 32'(v.e_rwen));
            chk({v.name, ".ramaddr"},  bus.ramaddr,     v.e_raddr);
            chk({v.name, ".ramstore"}, bus.ramstore,    v.e_rstore);
            chk({v.name, ".iload"},    bus.iload,       v.rload);
            chk({v.name, ".dload"},    bus.dload,       v.rload);
            chk({v.name, ".err_o"},    32'(err),        32'(v.e_err));
            $display("vec %0d %s: iwait=%b dwait=%b ramREN=%b ramWEN=%b ramaddr=%h err_o=%b",
                     i, v.name, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, err);
            @(posedge clk);
            #1;
        end

        // Starvation: data and fetch both held, zero-wait RAM. Expect four
        // data completions, one fetch completion, then data again.
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ncomp = 0;
        rst = 1'b0;
        bus.iREN = 1'b1;  bus.iaddr = 32'h600;
        bus.dREN = 1'b1;  bus.dWEN  = 1'b0;  bus.daddr = 32'h700;  bus.dstore = 32'h0;
        bus.ramstate = ACCESS;  bus.ramload = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (!bus.iwait && !bus.dwait) begin
                chk("starve.both_waits_low", 32'd1, 32'd0);
            end
            if (!bus.iwait || !bus.dwait) begin
                if (ncomp < 7) begin
                    chk($sformatf("starve.grant%0d_is_data", ncomp), 32'(!bus.dwait), 32'(exp_seq[ncomp]));
                    chk($sformatf("starve.grant%0d_addr", ncomp), bus.ramaddr,
                        exp_seq[ncomp] ? 32'h700 : 32'h600);
                end
                $display("starve cycle %0d: completion %0d by %s addr=%h",
                         c, ncomp, bus.dwait ? "fetch" : "data", bus.ramaddr);
                ncomp++;
            end
            @(posedge clk);
            #1;
        end
        chk("starve.completions", 32'(ncomp), 32'd7);

        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.ramstate = FREE;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
